// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam logic [DIV_XLEN-1:0] DIV0_QUOT = {DIV_XLEN{1'b1}};
    localparam logic [DIV_XLEN-1:0] OVF_QUOT  = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: produces one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < |b| always holds, so the shifted partial remainder fits XLEN+1 bits
    // and the MSB of the difference is its sign.
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {1'b0, b_i};

    assign rem_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M divide/remainder sequencer with valid/ready request and response.
// state | meaning
// IDLE  | waiting for a request (req_ready high)
// CALC  | restoring loop, one quotient bit per cycle
// FIX   | sign fix-up and op select into the result register
// DONE  | result held until resp_ready
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  data_q, data_d;
    div_op_e          op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic [XLEN-1:0]  step_rem, step_quo;
    logic [XLEN-1:0]  a_mag, b_mag, quo_fix, rem_fix;
    logic             is_signed, a_neg, b_neg, div0, ovf, accept;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .b_i   (b_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign is_signed = ~req_op[0];
    assign a_neg     = is_signed & req_a[XLEN-1];
    assign b_neg     = is_signed & req_b[XLEN-1];
    assign a_mag     = a_neg ? -req_a : req_a;
    assign b_mag     = b_neg ? -req_b : req_b;
    assign div0      = (req_b == '0);
    assign ovf       = is_signed && (req_a == OVF_QUOT) && (req_b == DIV0_QUOT);
    assign accept    = req_valid && !flush;
    assign quo_fix   = q_neg_q ? -quo_q : quo_q;
    assign rem_fix   = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        data_d  = data_q;
        op_d    = op_q;
        tag_d   = tag_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = div_op_e'(req_op);
                    tag_d   = req_tag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    b_d     = b_mag;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    if (div0 || ovf) begin
                        // Fast path: remainder of a divide-by-zero is the raw dividend.
                        if (req_op[1]) data_d = div0 ? req_a : '0;
                        else           data_d = div0 ? DIV0_QUOT : OVF_QUOT;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                data_d  = op_q[1] ? rem_fix : quo_fix;
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
        endcase

        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            data_q  <= '0;
            op_q    <= OP_DIV;
            tag_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            data_q  <= data_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed plan vectors plus randomized ops vs an arithmetic model.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk, rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_a, req_b, resp_data;
    logic [TAG_W-1:0] req_tag, resp_tag;

    int n_cmp = 0;
    int n_err = 0;

    div_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want summary before it");
        $fatal(1, "watchdog");
    end

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn, ovf;
        sgn = !op[0];
        ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'h0) return op[1] ? a : DIV0_QUOT;
        if (ovf)        return op[1] ? 32'h0 : OVF_QUOT;
        if (sgn)        return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Index k of the edge E_k (E0 = accept) after which resp_valid is first seen high.
    function automatic int ref_edge(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic rdy);
        @(negedge clk);
        rdy       = req_ready;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = 5'($urandom);
        req_op    = 2'($urandom);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        @(negedge clk);
        while (!resp_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          output logic rdy, output int k, output logic [31:0] d, output logic [4:0] t);
        issue(op, a, b, tag, rdy);
        wait_valid(k);
        d = resp_data;
        t = resp_tag;
        consume();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'b00; req_a = '0; req_b = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_cmp++; if (resp_tag !== 5'h0)   begin n_err++; $display("FAIL reset_resp_tag: got %h want 0", resp_tag); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [12] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10,
                                   2'b00, 2'b10, 2'b01, 2'b11};
        logic [31:0] as   [12] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000,
                                   32'h8000_0000, 32'h7, 32'h7, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'h2, 32'h2, 32'h10, 32'h10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h3, 32'hFFFF_FFFE, 32'h0, 32'h0};
        logic [31:0] exps [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h0000_000F,
                                   32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000,
                                   32'hD555_5556, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        int          edgs [12] = '{33, 33, 33, 33, 0, 0, 0, 0, 33, 33, 0, 0};
        logic [4:0]  tags [12] = '{5'h03, 5'h04, 5'h1A, 5'h1A, 5'h05, 5'h06, 5'h07, 5'h08,
                                   5'h09, 5'h0A, 5'h0B, 5'h1F};
        logic        rdy;
        int          k;
        logic [31:0] d;
        logic [4:0]  t;
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], as[i], bs[i], tags[i], rdy, k, d, t);
            n_cmp++; if (rdy !== 1'b1)  begin n_err++; $display("FAIL dir%0d_ready: got %b want 1", i, rdy); end
            n_cmp++; if (d !== exps[i]) begin n_err++; $display("FAIL dir%0d_data: got %h want %h", i, d, exps[i]); end
            n_cmp++; if (t !== tags[i]) begin n_err++; $display("FAIL dir%0d_tag: got %h want %h", i, t, tags[i]); end
            n_cmp++; if (k != edgs[i])  begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, k, edgs[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        int   k;
        issue(2'b01, 32'd1000, 32'd3, 5'h0C, rdy);
        wait_valid(k);
        n_cmp++; if (k != 33) begin n_err++; $display("FAIL bp_latency: got %0d want 33", k); end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b00;
            req_b     = 32'h0;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b1)   begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid); end
            n_cmp++; if (resp_data !== 32'd333) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, resp_data, 32'd333); end
            n_cmp++; if (resp_tag !== 5'h0C)    begin n_err++; $display("FAIL bp_tag[%0d]: got %h want 0c", i, resp_tag); end
            n_cmp++; if (req_ready !== 1'b0)    begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL bp_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_flush_beats_accept();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'h5; req_b = 32'h0; flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL fba_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fba_resp_valid: got %b want 0", resp_valid); end
    endtask

    // Kill an op on its 10th CALC cycle using flush (use_rst=0) or rst (use_rst=1).
    task automatic test_abort(input logic use_rst);
        logic        rdy;
        int          k, bad;
        logic [31:0] d;
        logic [4:0]  t;
        issue(2'b01, $urandom, $urandom | 32'h1, 5'h11, rdy);
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort%0d_busy_before: got %b want 1", use_rst, busy); end
        req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1)  begin n_err++; $display("FAIL abort%0d_req_ready: got %b want 1", use_rst, req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL abort%0d_resp_valid: got %b want 0", use_rst, resp_valid); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL abort%0d_busy: got %b want 0", use_rst, busy); end
        if (use_rst) begin
            n_cmp++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL abort_rst_data: got %h want 0", resp_data); end
            n_cmp++; if (resp_tag !== 5'h0)   begin n_err++; $display("FAIL abort_rst_tag: got %h want 0", resp_tag); end
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL abort%0d_quiet: got %0d active cycles want 0", use_rst, bad); end
        run_op(2'b01, 32'd100, 32'd7, 5'h15, rdy, k, d, t);
        n_cmp++; if (rdy !== 1'b1)  begin n_err++; $display("FAIL abort%0d_new_ready: got %b want 1", use_rst, rdy); end
        n_cmp++; if (d !== 32'd14)  begin n_err++; $display("FAIL abort%0d_new_data: got %h want %h", use_rst, d, 32'd14); end
        n_cmp++; if (t !== 5'h15)   begin n_err++; $display("FAIL abort%0d_new_tag: got %h want 15", use_rst, t); end
        n_cmp++; if (k != 33)       begin n_err++; $display("FAIL abort%0d_new_latency: got %0d want 33", use_rst, k); end
    endtask

    // Randomized ops issued back to back, with random consumer delay.
    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, d, exp_d;
        logic [4:0]  tag, t;
        logic        rdy;
        int          k, exp_k, sel;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            tag = 5'($urandom);
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin
                a = $urandom_range(0, 300);
                b = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            exp_d = ref_result(op, a, b);
            exp_k = ref_edge(op, a, b);
            issue(op, a, b, tag, rdy);
            wait_valid(k);
            d = resp_data;
            t = resp_tag;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume();
            n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rnd%0d_ready: got %b want 1", i, rdy); end
            n_cmp++; if (d !== exp_d)  begin n_err++; $display("FAIL rnd%0d_data op=%0d a=%h b=%h: got %h want %h", i, op, a, b, d, exp_d); end
            n_cmp++; if (t !== tag)    begin n_err++; $display("FAIL rnd%0d_tag: got %h want %h", i, t, tag); end
            n_cmp++; if (k != exp_k)   begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, k, exp_k); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush_beats_accept();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
